// File: rtl/sampqueue_pkg.sv
// sampqueue_pkg
// Shared types and constants for the sample queue / byte serializer.
//   ser_state_e : serializer state encoding (idle / shifting a sample out)
//   DROP_SAT    : value at which the dropped-sample counter stops counting
//   idxWidth()  : width of a byte index for a given byte count (min 1 bit)
package sampqueue_pkg;

   typedef enum logic {
      SER_IDLE  = 1'b0,
      SER_SHIFT = 1'b1
   } ser_state_e;

   localparam logic [7:0] DROP_SAT = 8'hFF;

   // A single-byte sample still needs a 1-bit index register.
   function automatic int idxWidth(input int nBytes);
      return (nBytes > 1) ? $clog2(nBytes) : 1;
   endfunction

endpackage

// File: rtl/sampqueue_syncfifo.sv
// sampqueue_syncfifo
// Single-clock FIFO with RAM-style storage. Pointers carry one extra bit so
// full and empty can be told apart when the low bits match.
// The caller is responsible for not pushing when full (unless also popping)
// and for not popping when empty.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (pointers only)
//   push_i       : write push_data_i at the write pointer
//   push_data_i  : entry to store
//   pop_i        : advance the read pointer
//   pop_data_o   : entry at the read pointer (valid when not empty)
//   level_o      : number of entries held
//   full_o       : all 2**DEPTH_LOG2 slots occupied
//   empty_o      : no entries held
module sampqueue_syncfifo #(
   parameter int WIDTH      = 72,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      push_data_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      pop_data_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [DEPTH_LOG2:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2:0] rptr_q, rptr_d;

   // Storage has no reset so it maps onto a plain RAM. When full, a
   // simultaneous push and pop hit the same slot; the read side sees the
   // old contents because the write lands at the clock edge.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wptr_q[DEPTH_LOG2-1:0]] <= push_data_i;
      end
   end

   // Pointer advance.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_i) begin
         wptr_d = wptr_q + PTR_ONE;
      end
      if (pop_i) begin
         rptr_d = rptr_q + PTR_ONE;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Status: MSBs differing with equal low bits means the writer lapped the reader.
   assign pop_data_o = mem_q[rptr_q[DEPTH_LOG2-1:0]];
   assign level_o    = wptr_q - rptr_q;
   assign empty_o    = (wptr_q == rptr_q);
   assign full_o     = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                       (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);

endmodule

// File: rtl/sampqueue.sv
// sampqueue
// Buffers sample entries from the channel block while a capture sequence is
// active and serializes each entry as a little-endian byte stream over a
// valid/ready handshake. Samples that find no room are counted as drops.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   sq_active     : capture sequence active; rising edge clears drop stats
//   sample        : sample entry, qualified by sample_avail
//   sample_avail  : one-cycle strobe marking sample valid
//   out_data      : current byte of the sample in the shifter
//   out_valid     : out_data is valid
//   out_ready     : consumer takes the byte when high with out_valid
//   level         : entries in the FIFO (not counting the shifter)
//   overflow      : sticky, at least one sample dropped
//   drop_cnt      : dropped samples, saturating at 255
module sampqueue
   import sampqueue_pkg::*;
#(
   parameter int SAMPLE_W   = 72,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sq_active,
   input  logic [SAMPLE_W-1:0]   sample,
   input  logic                  sample_avail,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic [7:0]            drop_cnt
);

   localparam int BYTES = SAMPLE_W / 8;
   localparam int IDX_W = idxWidth(BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   ser_state_e          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [SAMPLE_W-1:0] shift_q, shift_d;
   logic                active_q;
   logic                overflow_q, overflow_d;
   logic [7:0]          drop_cnt_q, drop_cnt_d;

   logic                fifoFull, fifoEmpty;
   logic [SAMPLE_W-1:0] fifoHead;
   logic                handshake, lastByte, pop, push, writeReq, drop, activeRise;
   logic [7:0]          byteLane [BYTES];

   sampqueue_syncfifo #(
      .WIDTH      (SAMPLE_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (sample),
      .pop_i       (pop),
      .pop_data_o  (fifoHead),
      .level_o     (level),
      .full_o      (fifoFull),
      .empty_o     (fifoEmpty)
   );

   // Control decode. A pop happens when the shifter is free, or when its
   // last byte is being taken this cycle, so back-to-back samples have no
   // bubble. A pop in the same cycle frees a slot for an incoming sample
   // even when the FIFO is full.
   always_comb begin
      handshake  = (state_q == SER_SHIFT) && out_ready;
      lastByte   = (idx_q == LAST_IDX);
      pop        = !fifoEmpty && ((state_q == SER_IDLE) || (handshake && lastByte));
      writeReq   = sample_avail && sq_active;
      push       = writeReq && (!fifoFull || pop);
      drop       = writeReq && !push;
      activeRise = sq_active && !active_q;
   end

   // Serializer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SER_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Serializer next state: stay in SHIFT while entries keep arriving at the
   // head; fall back to IDLE only when the last byte leaves with nothing queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SER_IDLE: begin
            if (pop) begin
               state_d = SER_SHIFT;
            end
         end
         SER_SHIFT: begin
            if (handshake && lastByte && !pop) begin
               state_d = SER_IDLE;
            end
         end
         default: state_d = SER_IDLE;
      endcase
   end

   // Shifter and byte index. Loading a new sample always restarts at byte 0.
   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      if (pop) begin
         shift_d = fifoHead;
         idx_d   = '0;
      end else if (handshake) begin
         idx_d = lastByte ? '0 : (idx_q + IDX_ONE);
      end
   end

   // Drop accounting. The rising-edge clear takes priority over a drop in
   // the same cycle, so that drop is not recorded.
   always_comb begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (activeRise) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != DROP_SAT) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end
   end

   // Datapath and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q    <= '0;
         idx_q      <= '0;
         active_q   <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         shift_q    <= shift_d;
         idx_q      <= idx_d;
         active_q   <= sq_active;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Byte lanes of the shifter, byte 0 being the least significant.
   always_comb begin
      for (int b = 0; b < BYTES; b++) begin
         byteLane[b] = shift_q[8*b +: 8];
      end
   end

   // Outputs: data is forced to zero outside SHIFT so idle looks like reset.
   always_comb begin
      out_valid = (state_q == SER_SHIFT);
      out_data  = (state_q == SER_SHIFT) ? byteLane[idx_q] : 8'h00;
   end

   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_sampqueue.sv
// tb_sampqueue
// Self-checking bench for sampqueue. A queue-based reference model tracks the
// FIFO contents, the sample being serialized and the drop statistics, and
// every cycle the DUT outputs are compared against it.
module tb_sampqueue;

   localparam int SAMPLE_W   = 72;
   localparam int DEPTH_LOG2 = 4;
   localparam int BYTES      = SAMPLE_W / 8;
   localparam int DEPTH      = 2**DEPTH_LOG2;

   logic                  clk;
   logic                  rst_n;
   logic                  sq_active;
   logic [SAMPLE_W-1:0]   sample;
   logic                  sample_avail;
   logic [7:0]            out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DEPTH_LOG2:0]   level;
   logic                  overflow;
   logic [7:0]            drop_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [SAMPLE_W-1:0] mq [$];
   logic [SAMPLE_W-1:0] msh;
   int                  midx;
   bit                  mbusy;
   bit                  mact;
   bit                  movf;
   int                  mdc;

   logic [7:0] seenBytes [$];

   sampqueue #(
      .SAMPLE_W   (SAMPLE_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sq_active    (sq_active),
      .sample       (sample),
      .sample_avail (sample_avail),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .level        (level),
      .overflow     (overflow),
      .drop_cnt     (drop_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      msh   = '0;
      midx  = 0;
      mbusy = 0;
      mact  = 0;
      movf  = 0;
      mdc   = 0;
   endtask

   // One clock edge of the queue behaviour, using the inputs held this cycle.
   task automatic modelStep();
      bit hs, doPop, wr, acc, rise;
      hs    = mbusy && (out_ready == 1'b1);
      doPop = (mq.size() > 0) && (!mbusy || (hs && midx == BYTES - 1));
      wr    = (sample_avail == 1'b1) && (sq_active == 1'b1);
      acc   = wr && ((mq.size() < DEPTH) || doPop);
      rise  = (sq_active == 1'b1) && !mact;
      if (doPop) begin
         msh   = mq.pop_front();
         midx  = 0;
         mbusy = 1;
      end else if (hs) begin
         if (midx == BYTES - 1) begin
            mbusy = 0;
            midx  = 0;
         end else begin
            midx++;
         end
      end
      if (acc) mq.push_back(sample);
      if (rise) begin
         movf = 0;
         mdc  = 0;
      end else if (wr && !acc) begin
         movf = 1;
         if (mdc < 255) mdc++;
      end
      mact = (sq_active == 1'b1);
   endtask

   task automatic compareAll();
      logic [7:0] expData;
      expData = mbusy ? msh[8*midx +: 8] : 8'h00;
      checkOutput("out_valid", 32'(out_valid), 32'(mbusy));
      checkOutput("out_data",  32'(out_data),  32'(expData));
      checkOutput("level",     32'(level),     32'(mq.size()));
      checkOutput("overflow",  32'(overflow),  32'(movf));
      checkOutput("drop_cnt",  32'(drop_cnt),  32'(mdc));
   endtask

   // Drive one cycle of inputs, advance the model at the edge, compare after it.
   task automatic applyStimulus(input logic act, input logic avail, input logic rdy,
                                input logic [SAMPLE_W-1:0] smp);
      @(negedge clk);
      sq_active    = act;
      sample_avail = avail;
      out_ready    = rdy;
      sample       = smp;
      @(posedge clk);
      modelStep();
      #1;
      compareAll();
   endtask

   function automatic logic [SAMPLE_W-1:0] randSample();
      logic [95:0] tmp;
      tmp = {$urandom, $urandom, $urandom};
      return tmp[SAMPLE_W-1:0];
   endfunction

   // Asynchronous reset pulse between clock edges; outputs must clear at once.
   task automatic pulseReset();
      #2;
      rst_n        = 1'b0;
      sq_active    = 1'b0;
      sample_avail = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data",  32'(out_data),  32'd0);
      checkOutput("rst_level",     32'(level),     32'd0);
      checkOutput("rst_overflow",  32'(overflow),  32'd0);
      checkOutput("rst_drop_cnt",  32'(drop_cnt),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [SAMPLE_W-1:0] fixedSample;
      rst_n        = 1'b0;
      sq_active    = 1'b0;
      sample       = '0;
      sample_avail = 1'b0;
      out_ready    = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("init_out_valid", 32'(out_valid), 32'd0);
      checkOutput("init_out_data",  32'(out_data),  32'd0);
      checkOutput("init_level",     32'(level),     32'd0);
      checkOutput("init_overflow",  32'(overflow),  32'd0);
      checkOutput("init_drop_cnt",  32'(drop_cnt),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single known sample: bytes must appear as 01..09 in order.
      fixedSample = 72'h090807060504030201;
      applyStimulus(1'b1, 1'b1, 1'b1, fixedSample);
      seenBytes.delete();
      for (int c = 0; c < 14; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, '0);
         if (out_valid === 1'b1) seenBytes.push_back(out_data);
      end
      checkOutput("single_count", 32'(seenBytes.size()), 32'(BYTES));
      for (int b = 0; b < BYTES; b++) begin
         if (b < seenBytes.size()) begin
            checkOutput("single_byte", 32'(seenBytes[b]), 32'(b + 1));
         end
      end

      // Three back-to-back samples with a ready consumer.
      for (int s = 0; s < 3; s++) applyStimulus(1'b1, 1'b1, 1'b1, randSample());
      repeat (35) applyStimulus(1'b1, 1'b0, 1'b1, '0);

      // Fill with the consumer stalled, then keep pushing to force drops.
      repeat (25) applyStimulus(1'b1, 1'b1, 1'b0, randSample());
      // Drop once the capture sequence ends, then restart: stats clear.
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, randSample());
      repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, randSample());
      // Consumer resumes while the producer keeps the FIFO full.
      repeat (60) applyStimulus(1'b1, 1'b1, 1'b1, randSample());
      repeat (170) applyStimulus(1'b1, 1'b0, 1'b1, '0);

      // Saturate the drop counter.
      repeat (280) applyStimulus(1'b1, 1'b1, 1'b0, randSample());
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      repeat (170) applyStimulus(1'b1, 1'b0, 1'b1, '0);

      // Consumer toggling every other cycle with random arrivals.
      for (int c = 0; c < 200; c++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 3) == 0), 1'(c % 2), randSample());
      end
      repeat (200) applyStimulus(1'b1, 1'b0, 1'b1, '0);

      // Fully random traffic including capture on/off.
      for (int c = 0; c < 400; c++) begin
         applyStimulus(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) != 0), randSample());
      end

      // Reset in the middle of a sample.
      applyStimulus(1'b1, 1'b1, 1'b1, randSample());
      applyStimulus(1'b1, 1'b1, 1'b1, randSample());
      repeat (4) applyStimulus(1'b1, 1'b0, 1'b1, '0);
      pulseReset();
      repeat (20) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, randSample());
      repeat (40) applyStimulus(1'b1, 1'b0, 1'b1, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
